// File: rtl/booth_mult_sched.sv
// booth_mult_sched: round-robin scheduler in front of one shared 4x4 signed
// Booth multiplier. It grants one requester, registers that requester's
// operands, registers the product and returns it with the requester id.

// Combinational radix-2 Booth multiplier, signed W x W -> 2W.
module booth4bit #(
   parameter int unsigned W = 4
) (
   input  logic [W-1:0]   a_i,
   input  logic [W-1:0]   b_i,
   output logic [2*W-1:0] p_o
);

   logic [2*W-1:0] a_ext;
   logic           prev_bit;

   // Scan the multiplier bit pairs: 01 adds the shifted multiplicand, 10 subtracts it.
   always_comb begin
      a_ext    = {{W{a_i[W-1]}}, a_i};
      p_o      = '0;
      prev_bit = 1'b0;
      for (int unsigned i = 0; i < W; i++) begin
         case ({b_i[i], prev_bit})
            2'b01:   p_o = p_o + (a_ext << i);
            2'b10:   p_o = p_o - (a_ext << i);
            default: p_o = p_o;
         endcase
         prev_bit = b_i[i];
      end
   end

endmodule

module booth_mult_sched #(
   parameter int unsigned NREQ  = 2,
   parameter int unsigned WIDTH = 4
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [NREQ-1:0]                      req_valid_i,
   output logic [NREQ-1:0]                      req_ready_o,
   input  logic [NREQ*WIDTH-1:0]                req_a_i,
   input  logic [NREQ*WIDTH-1:0]                req_b_i,
   output logic                                 rsp_valid_o,
   input  logic                                 rsp_ready_i,
   output logic [(NREQ > 1 ? $clog2(NREQ) : 1)-1:0] rsp_id_o,
   output logic [2*WIDTH-1:0]                   rsp_p_o
);

   localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned PW  = 2 * WIDTH;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      RESP = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [IDW-1:0]   id_q, id_d;
   logic [IDW-1:0]   last_q, last_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [IDW-1:0]   rsp_id_q, rsp_id_d;
   logic [PW-1:0]    rsp_p_q, rsp_p_d;

   logic             grant_vld;
   int unsigned      grant_sel;
   int unsigned      cand;
   logic [PW-1:0]    prod;

   // The operand registers feed the multiplier directly; its result is captured in MUL.
   booth4bit #(.W(WIDTH)) u_booth (
      .a_i (a_q),
      .b_i (b_q),
      .p_o (prod)
   );

   // Rotating priority: search from the requester after the last winner, wrapping.
   always_comb begin
      grant_vld = 1'b0;
      grant_sel = 0;
      cand      = 0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         cand = (32'(last_q) + k) % NREQ;
         if (!grant_vld && req_valid_i[cand]) begin
            grant_vld = 1'b1;
            grant_sel = cand;
         end
      end
   end

   // Next-state, operand capture and response update; req_ready is combinational.
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      id_d        = id_q;
      last_d      = last_q;
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_p_d     = rsp_p_q;
      req_ready_o = '0;
      case (state_q)
         IDLE: begin
            if (grant_vld) begin
               req_ready_o[grant_sel] = rst_n;
               a_d     = req_a_i[grant_sel*WIDTH +: WIDTH];
               b_d     = req_b_i[grant_sel*WIDTH +: WIDTH];
               id_d    = IDW'(grant_sel);
               last_d  = IDW'(grant_sel);
               state_d = MUL;
            end
         end
         MUL: begin
            rsp_p_d     = prod;
            rsp_id_d    = id_q;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
         end
         RESP: begin
            if (rsp_ready_i) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset discards any in-flight product.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         id_q        <= '0;
         last_q      <= IDW'(NREQ - 1);
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_p_q     <= '0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         id_q        <= id_d;
         last_q      <= last_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_p_q     <= rsp_p_d;
      end
   end

   assign rsp_valid_o = rsp_valid_q;
   assign rsp_id_o    = rsp_id_q;
   assign rsp_p_o     = rsp_p_q;

endmodule
